// File: rtl/set_engine_p.sv
// set_engine_p: parametrised multi-lane counter of grid points inside a set relation over three circles
module set_engine_p #(
    parameter int GRID_N  = 8,
    parameter int NUM_PE  = 4,
    parameter int COORD_W = 4,
    parameter int CNT_W   = $clog2(GRID_N*GRID_N+1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [6*COORD_W-1:0] central_i,
    input  logic [3*COORD_W-1:0] radius_i,
    input  logic [1:0]           mode_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [CNT_W-1:0]     candidate_o
);
    localparam int TOT = GRID_N*GRID_N;
    localparam int PW  = $clog2(TOT+NUM_PE+1);
    localparam int XW  = COORD_W+1;
    localparam int DW  = COORD_W+2;
    localparam int SW  = 2*COORD_W+3;
    localparam logic [PW-1:0] TOT_P = PW'(TOT);
    localparam logic [PW-1:0] NUM_P = PW'(NUM_PE);
    localparam logic [PW-1:0] GN_P  = PW'(GRID_N);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t               state_q;
    logic                 busy_q, valid_q, drain_q;
    logic [PW-1:0]        p_q;
    logic [1:0]           mode_q;
    logic [6*COORD_W-1:0] cen_q;
    logic [3*COORD_W-1:0] rad_q;
    logic [PW-1:0]        p_d [NUM_PE];
    logic [XW-1:0]        x_d [NUM_PE];
    logic [XW-1:0]        y_d [NUM_PE];
    logic [NUM_PE-1:0]    m_d;
    logic [XW-1:0]        x_q [NUM_PE];
    logic [XW-1:0]        y_q [NUM_PE];
    logic [NUM_PE-1:0]    m_q;
    logic [2:0]           in_d [NUM_PE];
    logic [NUM_PE-1:0]    hit_d, hit_q;
    logic                 s1v_q, s2v_q;
    logic [CNT_W-1:0]     pop_d, acc_q;

    // boundary points count as inside; the wide signed math cannot overflow for any legal input
    function automatic logic inside_c(input logic [XW-1:0] x, y,
                                      input logic [COORD_W-1:0] xc, yc, r);
        logic signed [DW-1:0] dx, dy;
        logic signed [SW-1:0] ex, ey;
        logic [SW-1:0]        re;
        dx = $signed({1'b0, x}) - $signed({2'b0, xc});
        dy = $signed({1'b0, y}) - $signed({2'b0, yc});
        ex = SW'(dx);
        ey = SW'(dy);
        re = SW'(r);
        return $unsigned(ex*ex + ey*ey) <= re*re;
    endfunction

    // control FSM: accept a job, scan all batches, drain the pipeline, strobe the result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            drain_q <= 1'b0;
            p_q     <= '0;
            mode_q  <= '0;
            cen_q   <= '0;
            rad_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (en_i) begin
                    state_q <= SCAN;
                    busy_q  <= 1'b1;
                    p_q     <= '0;
                    mode_q  <= mode_i;
                    cen_q   <= central_i;
                    rad_q   <= radius_i;
                end
                SCAN: begin
                    p_q <= p_q + NUM_P;
                    if (p_q + NUM_P >= TOT_P) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // raster coordinates of the current batch; lanes past the last grid point are masked
    always_comb begin
        for (int j = 0; j < NUM_PE; j++) begin
            p_d[j] = p_q + PW'(j);
            x_d[j] = XW'(p_d[j] % GN_P) + XW'(1);
            y_d[j] = XW'(p_d[j] / GN_P) + XW'(1);
            m_d[j] = p_d[j] < TOT_P;
        end
    end

    // per-lane circle inclusion {a,b,c} and the mode-selected hit bit
    always_comb begin
        hit_d = '0;
        for (int j = 0; j < NUM_PE; j++) begin
            for (int k = 0; k < 3; k++)
                in_d[j][2-k] = inside_c(x_q[j], y_q[j],
                                        cen_q[(6-2*k)*COORD_W-1 -: COORD_W],
                                        cen_q[(5-2*k)*COORD_W-1 -: COORD_W],
                                        rad_q[(3-k)*COORD_W-1 -: COORD_W]);
            hit_d[j] = m_q[j] & ((mode_q == 2'd0) ? in_d[j][2] :
                                 (mode_q == 2'd1) ? in_d[j][2] & in_d[j][1] :
                                 (mode_q == 2'd2) ? in_d[j][2] ^ in_d[j][1] :
                                 (in_d[j] == 3'b110) | (in_d[j] == 3'b101) | (in_d[j] == 3'b011));
        end
    end

    // popcount of the registered hit vector
    always_comb begin
        pop_d = '0;
        for (int j = 0; j < NUM_PE; j++)
            pop_d = pop_d + CNT_W'(hit_q[j]);
    end

    // two pipeline stages (coordinates, hits) feeding the accumulator
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            x_q   <= '{default: '0};
            y_q   <= '{default: '0};
            m_q   <= '0;
            hit_q <= '0;
            s1v_q <= 1'b0;
            s2v_q <= 1'b0;
            acc_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            m_q   <= m_d;
            hit_q <= hit_d;
            s1v_q <= state_q == SCAN;
            s2v_q <= s1v_q;
            acc_q <= (state_q == IDLE && en_i) ? '0 : s2v_q ? acc_q + pop_d : acc_q;
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign candidate_o = acc_q;
endmodule

// File: tb/tb_set_engine_p.sv
// tb_set_engine_p: table-driven scoreboard bench for set_engine_p at three parameter sets
module tb_set_engine_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        en0 = 1'b0, busy0, valid0;
    logic [23:0] cen0 = '0;
    logic [11:0] rad0 = '0;
    logic [1:0]  mode0 = '0;
    logic [6:0]  cand0;
    set_engine_p u0 (.clk_i(clk), .rst_i(rst_n), .en_i(en0), .central_i(cen0), .radius_i(rad0),
                     .mode_i(mode0), .busy_o(busy0), .valid_o(valid0), .candidate_o(cand0));

    logic        en1 = 1'b0, busy1, valid1;
    logic [23:0] cen1 = '0;
    logic [11:0] rad1 = '0;
    logic [6:0]  cand1;
    set_engine_p #(.NUM_PE(3)) u1 (.clk_i(clk), .rst_i(rst_n), .en_i(en1), .central_i(cen1),
                     .radius_i(rad1), .mode_i(2'd0), .busy_o(busy1), .valid_o(valid1), .candidate_o(cand1));

    logic        en2 = 1'b0, busy2, valid2;
    logic [29:0] cen2 = '0;
    logic [14:0] rad2 = '0;
    logic [8:0]  cand2;
    set_engine_p #(.GRID_N(16), .COORD_W(5), .NUM_PE(8)) u2 (.clk_i(clk), .rst_i(rst_n), .en_i(en2),
                     .central_i(cen2), .radius_i(rad2), .mode_i(2'd0), .busy_o(busy2),
                     .valid_o(valid2), .candidate_o(cand2));

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] cen;
        logic [11:0] rad;
        int          exp;
    } vec_t;
    vec_t vecs[12];

    int exp_q[$];
    int due_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // scoreboard: every valid strobe on the default instance pops one expected result
    always @(negedge clk) begin
        if (valid0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_valid: valid_o at cycle %0d with no job outstanding", cyc);
            end else begin
                check("candidate", cand0, exp_q.pop_front());
                check("latency", cyc, due_q.pop_front());
            end
        end
    end

    task automatic wait_valid0(input string nm);
        for (int i = 0; i < 40 && !valid0; i++) @(negedge clk);
        if (!valid0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: valid_o never rose", nm);
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic run0(input vec_t v);
        @(negedge clk);
        mode0 = v.mode; cen0 = v.cen; rad0 = v.rad; en0 = 1'b1;
        exp_q.push_back(v.exp);
        due_q.push_back(cyc + 19);
        @(negedge clk);
        en0 = 1'b0; mode0 = ~v.mode; cen0 = ~v.cen; rad0 = ~v.rad;
        check("busy_start", busy0, 1);
        wait_valid0("job");
        @(negedge clk);
        check("busy_end", busy0, 0);
        check("valid_pulse", valid0, 0);
    endtask

    task automatic run1(input string nm, input logic [23:0] c, input logic [11:0] r, input int exp);
        int due;
        @(negedge clk);
        cen1 = c; rad1 = r; en1 = 1'b1; due = cyc + 25;
        @(negedge clk);
        en1 = 1'b0;
        for (int i = 0; i < 60 && !valid1; i++) @(negedge clk);
        check({nm, "_valid"}, valid1, 1);
        check({nm, "_count"}, cand1, exp);
        check({nm, "_lat"}, cyc, due);
        @(negedge clk);
    endtask

    task automatic run2(input string nm, input logic [29:0] c, input logic [14:0] r, input int exp);
        int due;
        @(negedge clk);
        cen2 = c; rad2 = r; en2 = 1'b1; due = cyc + 35;
        @(negedge clk);
        en2 = 1'b0;
        for (int i = 0; i < 80 && !valid2; i++) @(negedge clk);
        check({nm, "_valid"}, valid2, 1);
        check({nm, "_count"}, cand2, exp);
        check({nm, "_lat"}, cyc, due);
        @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, 24'h440000, 12'h200, 13};
        vecs[1]  = '{2'd0, 24'h110000, 12'h100, 3};
        vecs[2]  = '{2'd0, 24'h440000, 12'hF00, 64};
        vecs[3]  = '{2'd0, 24'h440000, 12'h000, 1};
        vecs[4]  = '{2'd1, 24'h444400, 12'h220, 13};
        vecs[5]  = '{2'd2, 24'h444400, 12'h220, 0};
        vecs[6]  = '{2'd2, 24'h227700, 12'h000, 2};
        vecs[7]  = '{2'd3, 24'h444488, 12'h220, 13};
        vecs[8]  = '{2'd3, 24'h444444, 12'h222, 0};
        vecs[9]  = '{2'd0, 24'h000000, 12'h300, 4};
        vecs[10] = '{2'd1, 24'h4454FF, 12'h21F, 5};
        vecs[11] = '{2'd2, 24'h4454FF, 12'h21F, 8};

        repeat (3) @(negedge clk);
        check("rst_busy0", busy0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_cand0", cand0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_cand1", cand1, 0);
        check("rst_busy2", busy2, 0);
        check("rst_cand2", cand2, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run0(vecs[i]);

        // en_i held high: one result, then a fresh job only once back in IDLE
        @(negedge clk);
        mode0 = vecs[0].mode; cen0 = vecs[0].cen; rad0 = vecs[0].rad; en0 = 1'b1;
        exp_q.push_back(13);
        due_q.push_back(cyc + 19);
        wait_valid0("held");
        @(negedge clk);
        check("held_idle_busy", busy0, 0);
        exp_q.push_back(13);
        due_q.push_back(cyc + 19);
        @(negedge clk);
        en0 = 1'b0;
        check("held_restart_busy", busy0, 1);
        wait_valid0("held2");
        @(negedge clk);

        // asynchronous reset during SCAN batch 5 aborts the job
        @(negedge clk);
        mode0 = 2'd0; cen0 = 24'h440000; rad0 = 12'hF00; en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_valid", valid0, 0);
        check("abort_cand", cand0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_idle", busy0, 0);
        run0(vecs[2]);

        run1("pe3_full", 24'h440000, 12'hF00, 64);
        run1("pe3_mask", 24'h190000, 12'h000, 0);
        run1("pe3_corner", 24'h880000, 12'h100, 3);
        run2("g16_full", {5'd8, 5'd8, 20'd0}, {5'd31, 10'd0}, 256);
        run2("g16_corner", {5'd16, 5'd16, 20'd0}, {5'd1, 10'd0}, 3);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
